multi_cycle_ctrl: RTL and testbench

- Moore-style multi-cycle control FSM for the RISC datapath.
- Sequences one instruction over 3–5 cycles.
- Drives the three datapath mux selectors (register-destination mux, ALU operand-B mux, memory/ALU writeback mux) plus the PC, IR, register-file and memory enables.
- Waits on a memory-ready handshake and counts retired instructions.

---
 rtl/multi_cycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore-style control FSM for the multi-cycle RISC datapath.
// It sequences one instruction over 3-5 cycles, plus one extra cycle for each
// memory stall. It drives the datapath mux selects and the PC, IR, register
// file and memory enables, and it counts retired instructions.
//
// Handshake: i_mem_ready is sampled in FETCH, MEM_RD and MEM_WR. A cycle with
// i_mem_ready=1 completes the access, and the FSM leaves that state on the next
// rising edge. A cycle with i_mem_ready=0 holds the state and keeps the request
// asserted.
module multi_cycle_ctrl #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [OPCODE_WIDTH-1:0] iv_opcode,
  input  logic                    i_zero,
  input  logic                    i_mem_ready,
  output logic                    o_reg_dst,
  output logic                    o_alu_src,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_write,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic                    o_iord,
  output logic                    o_ir_write,
  output logic                    o_pc_write,
  output logic                    o_pc_write_cond,
  output logic [1:0]              ov_pc_src,
  output logic [1:0]              ov_alu_op,
  output logic                    o_illegal,
  output logic [3:0]              ov_state,
  output logic [CNT_WIDTH-1:0]    ov_retired
);

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t                  r_state;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [CNT_WIDTH-1:0]    r_retired;

  logic w_legal;
  logic w_retire;
  logic w_run;

  // The zero flag is consumed by the PC logic. It is tied off here so the port
  // stays part of the interface without affecting sequencing.
  logic w_zero_unused;
  assign w_zero_unused = i_zero;

  // While reset is high, every output is forced low without waiting for a clock.
  assign w_run = ~i_reset;

  // Classify the live opcode; only meaningful while in DECODE.
  always_comb begin
    w_legal = 1'b0;
    case (iv_opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
      default:                                   w_legal = 1'b0;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WR:                                   w_retire = i_mem_ready;
      default:                                    w_retire = 1'b0;
    endcase
  end

  // State sequencing, the opcode latch and the retired-instruction counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      case (r_state)
        S_FETCH: begin
          if (i_mem_ready) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_opcode <= iv_opcode;
          case (iv_opcode)
            OP_R:         r_state <= S_EXEC_R;
            OP_LW, OP_SW: r_state <= S_ADDR;
            OP_ADDI:      r_state <= S_EXEC_I;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_WB_R:   r_state <= S_FETCH;
        S_ADDR: begin
          // Decide from the latched opcode. By now the IR field may already
          // have moved on.
          if (r_opcode == OP_LW) begin
            r_state <= S_MEM_RD;
          end else if (r_opcode == OP_SW) begin
            r_state <= S_MEM_WR;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_RD: begin
          if (i_mem_ready) begin
            r_state <= S_WB_MEM;
          end
        end
        S_WB_MEM: r_state <= S_FETCH;
        S_MEM_WR: begin
          if (i_mem_ready) begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC_I: r_state <= S_WB_I;
        S_WB_I:   r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode. Only the FETCH IR/PC loads also look at i_mem_ready,
  // and DECODE flags an undefined opcode.
  always_comb begin
    o_reg_dst       = 1'b0;
    o_alu_src       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_iord          = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    ov_pc_src       = 2'b00;
    ov_alu_op       = 2'b00;
    o_illegal       = 1'b0;
    if (w_run) begin
      case (r_state)
        S_FETCH: begin
          o_mem_read = 1'b1;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src = 1'b1;
          o_illegal = ~w_legal;
        end
        S_EXEC_R: ov_alu_op = 2'b10;
        S_WB_R: begin
          o_reg_dst   = 1'b1;
          o_reg_write = 1'b1;
        end
        S_ADDR: o_alu_src = 1'b1;
        S_MEM_RD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        S_WB_MEM: begin
          o_mem_to_reg = 1'b1;
          o_reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        S_EXEC_I: o_alu_src = 1'b1;
        S_WB_I:   o_reg_write = 1'b1;
        S_BRANCH: begin
          ov_alu_op       = 2'b01;
          o_pc_write_cond = 1'b1;
          ov_pc_src       = 2'b01;
        end
        S_JUMP: begin
          o_pc_write = 1'b1;
          ov_pc_src  = 2'b10;
        end
        default: begin
          o_mem_read = 1'b0;
        end
      endcase
    end
  end

  assign ov_state   = r_state;
  assign ov_retired = r_retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl. The counter is narrowed to 4 bits so that the
// wrap-around case is reachable quickly.
module tb_multi_cycle_ctrl;

  localparam int OW = 6;
  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic          i_clk;
  logic          i_reset;
  logic [OW-1:0] iv_opcode;
  logic          i_zero;
  logic          i_mem_ready;
  logic          o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write;
  logic          o_mem_read, o_mem_write, o_iord, o_ir_write;
  logic          o_pc_write, o_pc_write_cond, o_illegal;
  logic [1:0]    ov_pc_src, ov_alu_op;
  logic [3:0]    ov_state;
  logic [CW-1:0] ov_retired;

  int checks   = 0;
  int failures = 0;

  // Each scoreboard entry is {mem_ready, expected state, opcode driven}.
  logic [10:0]   exp_q[$];
  logic [CW-1:0] exp_ret;

  multi_cycle_ctrl #(.OPCODE_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .iv_opcode(iv_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready), .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_iord(o_iord),
    .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
    .o_pc_write_cond(o_pc_write_cond), .ov_pc_src(ov_pc_src),
    .ov_alu_op(ov_alu_op), .o_illegal(o_illegal), .ov_state(ov_state),
    .ov_retired(ov_retired)
  );

  // Clock and reset defaults.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Packed controls: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_op, illegal}.
  function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                            input logic [5:0] op);
    logic [14:0] c;
    logic        bad;
    bad = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
            op == OP_ADDI || op == OP_J);
    c = '0;
    case (st)
      4'd0:  c = {4'b0000, 1'b1, 2'b00, rdy, rdy, 1'b0, 2'b00, 2'b00, 1'b0};
      4'd1:  c = {4'b0100, 3'b000, 3'b000, 2'b00, 2'b00, bad};
      4'd2:  c = {4'b0000, 3'b000, 3'b000, 2'b00, 2'b10, 1'b0};
      4'd3:  c = {4'b1001, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd4:  c = {4'b0100, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd5:  c = {4'b0000, 3'b101, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd6:  c = {4'b0011, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd7:  c = {4'b0000, 3'b011, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd8:  c = {4'b0100, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd9:  c = {4'b0001, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0};
      4'd10: c = {4'b0000, 3'b000, 3'b001, 2'b01, 2'b01, 1'b0};
      4'd11: c = {4'b0000, 3'b000, 3'b010, 2'b10, 2'b00, 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [14:0] act_ctrl();
    return {o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write, o_mem_read,
            o_mem_write, o_iord, o_ir_write, o_pc_write, o_pc_write_cond,
            ov_pc_src, ov_alu_op, o_illegal};
  endfunction

  // Push the expected per-cycle trace of one instruction onto the scoreboard.
  task automatic push_instr(input logic [5:0] op, input int fstall, input int mstall);
    for (int k = 0; k < fstall; k++) exp_q.push_back({1'b0, 4'd0, 6'($urandom_range(0, 63))});
    exp_q.push_back({1'b1, 4'd0, 6'($urandom_range(0, 63))});
    exp_q.push_back({1'($urandom_range(0, 1)), 4'd1, op});
    case (op)
      OP_R: begin
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd2, 6'($urandom_range(0, 63))});
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd3, 6'($urandom_range(0, 63))});
      end
      OP_LW, OP_SW: begin
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd4, 6'($urandom_range(0, 63))});
        for (int k = 0; k < mstall; k++)
          exp_q.push_back({1'b0, (op == OP_LW) ? 4'd5 : 4'd7, 6'($urandom_range(0, 63))});
        exp_q.push_back({1'b1, (op == OP_LW) ? 4'd5 : 4'd7, 6'($urandom_range(0, 63))});
        if (op == OP_LW)
          exp_q.push_back({1'($urandom_range(0, 1)), 4'd6, 6'($urandom_range(0, 63))});
      end
      OP_ADDI: begin
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd8, 6'($urandom_range(0, 63))});
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd9, 6'($urandom_range(0, 63))});
      end
      OP_BEQ: exp_q.push_back({1'($urandom_range(0, 1)), 4'd10, 6'($urandom_range(0, 63))});
      OP_J:   exp_q.push_back({1'($urandom_range(0, 1)), 4'd11, 6'($urandom_range(0, 63))});
      default: ;
    endcase
  endtask

  // Drive every queued cycle and compare the DUT against each entry as it is popped.
  task automatic drain(input string tag);
    logic [10:0] e;
    logic [14:0] ec;
    int          guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      guard++;
      e = exp_q.pop_front();
      @(negedge i_clk);
      i_mem_ready = e[10];
      iv_opcode   = e[5:0];
      #1;
      ec = exp_ctrl(e[9:6], e[10], e[5:0]);
      checks++;
      if (ov_state !== e[9:6]) begin
        failures++;
        $display("FAIL %s state: got %0d expected %0d", tag, ov_state, e[9:6]);
      end
      checks++;
      if (act_ctrl() !== ec) begin
        failures++;
        $display("FAIL %s ctrl st%0d: got %b expected %b", tag, e[9:6], act_ctrl(), ec);
      end
      checks++;
      if (ov_retired !== exp_ret) begin
        failures++;
        $display("FAIL %s retired: got %0d expected %0d", tag, ov_retired, exp_ret);
      end
      if (e[9:6] inside {4'd3, 4'd6, 4'd9, 4'd10, 4'd11} || (e[9:6] == 4'd7 && e[10]))
        exp_ret = exp_ret + 1'b1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_mem_ready = 1'b1; iv_opcode = OP_R; i_zero = 1'b0;
    exp_ret = '0;
    #12;
    checks++;
    if (ov_state !== 4'd0 || ov_retired !== '0 || act_ctrl() !== 15'd0) begin
      failures++;
      $display("FAIL reset_hold: state %0d ret %0d ctrl %b expected 0/0/0", ov_state, ov_retired, act_ctrl());
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_mem_read !== 1'b1 || ov_state !== 4'd0) begin
      failures++;
      $display("FAIL reset_release: mem_read %b state %0d expected 1/0", o_mem_read, ov_state);
    end
    // Start an R-type, then reset while it is in EXEC_R.
    @(negedge i_clk); iv_opcode = OP_R; i_mem_ready = 1'b1;
    @(negedge i_clk); i_mem_ready = 1'b0; iv_opcode = 6'h15;
    #1;
    checks++;
    if (ov_state !== 4'd2) begin
      failures++;
      $display("FAIL reset_pre: state %0d expected 2", ov_state);
    end
    #1 i_reset = 1'b1;
    #1;
    checks++;
    if (ov_state !== 4'd0 || ov_retired !== '0 || act_ctrl() !== 15'd0) begin
      failures++;
      $display("FAIL reset_async: state %0d ret %0d ctrl %b expected 0/0/0", ov_state, ov_retired, act_ctrl());
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_r_type();
    push_instr(OP_R, 0, 0);
    drain("r_type");
  endtask

  task automatic test_lw_stall();
    push_instr(OP_LW, 0, 3);
    drain("lw_stall");
  endtask

  task automatic test_sw_beq_j();
    push_instr(OP_SW, 0, 1);
    push_instr(OP_BEQ, 0, 0);
    push_instr(OP_J, 0, 0);
    drain("sw_beq_j");
  endtask

  task automatic test_illegal();
    push_instr(OP_BAD, 0, 0);
    push_instr(OP_ADDI, 0, 0);
    push_instr(6'b110011, 1, 0);
    drain("illegal");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
    for (int k = 0; k < 12; k++)
      push_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
    drain("back_to_back");
  endtask

  task automatic test_counter_wrap();
    logic [CW-1:0] start;
    start = exp_ret;
    for (int k = 0; k < 16; k++) push_instr(OP_ADDI, 0, 0);
    drain("wrap");
    // Sample in the FETCH after the 16th retirement.
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    #1;
    checks++;
    if (ov_retired !== start) begin
      failures++;
      $display("FAIL wrap_count: got %0d expected %0d", ov_retired, start);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw_beq_j();
    test_illegal();
    test_back_to_back();
    // Reset again so that 16 retirements wrap exactly to zero.
    test_reset();
    test_counter_wrap();
    checks++;
    if (ov_retired !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d expected 0", ov_retired);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
